// File: rtl/hv_bundler.sv
// Per-bit majority-vote bundler: saturating signed counters, registered threshold, valid/ready result.
// Optional HV_TIEBREAK_EN: tie bits come from a 32-bit Galois LFSR instead of resolving to 0.
module hv_bundler #(
  parameter int          DIM       = 32,
  parameter int          CNT_W     = 8,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_1234
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_v,
  output logic             in_r,
  input  logic [DIM-1:0]   in_d,
  input  logic             in_last,
  output logic             out_v,
  input  logic             out_r,
  output logic [DIM-1:0]   out_d,
  output logic [CNT_W-1:0] out_n,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam logic signed [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-2){1'b0}}, 1'b1};
  localparam logic signed [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                  state;
  logic signed [CNT_W-1:0] cnt     [DIM];
  logic signed [CNT_W-1:0] cnt_nxt [DIM];
  logic [CNT_W-1:0]        vec_cnt;
  logic [CNT_W-1:0]        vec_nxt;
  logic [DIM-1:0]          thr;
  logic [DIM-1:0]          tie_bits;
  logic                    accept;
  logic                    handshake;

  assign in_r      = (state != OUT);
  assign busy      = (state != IDLE);
  assign accept    = in_v && in_r && !clear;
  assign handshake = out_v && out_r && !clear;

`ifdef HV_TIEBREAK_EN
  logic [31:0] lfsr;

  // Advances once per delivered bundle; clear deliberately leaves it running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      lfsr <= LFSR_SEED;
    else if (handshake)
      lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0000_0000);
  end

  always_comb begin
    tie_bits = '0;
    for (int i = 0; i < DIM; i++)
      tie_bits[i] = lfsr[i % 32];
  end
`else
  assign tie_bits = '0;
`endif

  always_comb begin
    vec_nxt = (vec_cnt == {CNT_W{1'b1}}) ? vec_cnt : vec_cnt + CNT_W'(1);
    thr     = '0;
    for (int i = 0; i < DIM; i++) begin
      cnt_nxt[i] = cnt[i];
      if (in_d[i]) begin
        if (cnt[i] != CNT_MAX)
          cnt_nxt[i] = cnt[i] + CNT_ONE;
      end else begin
        if (cnt[i] != CNT_MIN)
          cnt_nxt[i] = cnt[i] - CNT_ONE;
      end
      // Threshold on the post-update count so the final beat votes too.
      if (cnt_nxt[i][CNT_W-1])
        thr[i] = 1'b0;
      else if (cnt_nxt[i] != '0)
        thr[i] = 1'b1;
      else
        thr[i] = tie_bits[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      vec_cnt <= '0;
      out_v   <= 1'b0;
      out_d   <= '0;
      out_n   <= '0;
      for (int i = 0; i < DIM; i++)
        cnt[i] <= '0;
    end else if (clear) begin
      state   <= IDLE;
      vec_cnt <= '0;
      out_v   <= 1'b0;
      for (int i = 0; i < DIM; i++)
        cnt[i] <= '0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            vec_cnt <= vec_nxt;
            for (int i = 0; i < DIM; i++)
              cnt[i] <= cnt_nxt[i];
            if (in_last) begin
              state <= OUT;
              out_v <= 1'b1;
              out_d <= thr;
              out_n <= vec_nxt;
            end else begin
              state <= ACC;
            end
          end
        end
        OUT: begin
          if (handshake) begin
            state   <= IDLE;
            out_v   <= 1'b0;
            vec_cnt <= '0;
            for (int i = 0; i < DIM; i++)
              cnt[i] <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hv_bundler.md
Name: hv_bundler

Overview:
- Downstream consumer of the per-core XOR/permute accumulators; receives one bound 32-bit hypervector per valid beat as the core chain shifts them out.
- Bundles N vectors by per-bit majority vote into one 32-bit class/query hypervector.
- Signed saturating per-bit counters, then a registered threshold stage.
- Result is held behind a valid/ready handshake for the host DMA.

Parameters:
DIM, 32, hypervector width in bits (matches core acc width)
CNT_W, 8, width of each signed per-bit counter and of the vector counter
LFSR_SEED, 32'hACE1_1234, nonzero seed for tie-break LFSR (used only with HV_TIEBREAK_EN)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
clear  input  1  synchronous abort: drop counters and any pending result
in_v  input  1  input vector valid
in_r  output  1  ready to accept input
in_d  input  DIM  bound hypervector from core chain
in_last  input  1  qualifies in_v beat as final vector of the bundle
out_v  output  1  bundled result valid
out_r  input  1  downstream ready
out_d  output  DIM  majority-vote hypervector
out_n  output  CNT_W  number of vectors bundled, saturating at 2^CNT_W-1
busy  output  1  high in ACC or OUT

Behaviour:
- Reset (rst low, async):
  - state=IDLE.
  - All counters = 0; vector count = 0.
  - out_v=0, out_d=0, out_n=0, busy=0, in_r=1.
  - LFSR = LFSR_SEED.
- States:
  - IDLE: accept first beat -> ACC; if that beat has in_last -> OUT.
  - ACC: accept beats; beat with in_last -> OUT.
  - OUT: hold result until out_v&out_r -> IDLE.
- in_r = 1 in IDLE and ACC, 0 in OUT. A beat is accepted when in_v&in_r.
- Per-bit update on accept: cnt[i] += in_d[i] ? +1 : -1.
  - Signed saturation at +(2^(CNT_W-1)-1) and -(2^(CNT_W-1)-1).
  - Saturated counters hold; no wrap.
- Vector count increments per accepted beat and saturates at 2^CNT_W-1.
- Threshold, computed in the same cycle as the last beat and registered:
  - bit=1 if the post-update cnt>0.
  - bit=0 if cnt<0.
  - tie (cnt==0): see Optional Feature.
- Latency: out_v rises the cycle after the in_last beat is accepted. out_d and out_n are registered and stable while out_v=1.
- On out_v&out_r:
  - counters and vector count clear.
  - out_v falls next cycle; state -> IDLE.
  - out_d/out_n keep their last value.
  - New input is accepted from the following cycle; no back-to-back accept in the handshake cycle.
- clear (synchronous):
  - Any state -> IDLE; counters and vector count zeroed; out_v=0.
  - Overrides a simultaneous accept or handshake; neither takes effect.
- in_v with in_r=0: ignored. The upstream holds data.
- Async reset mid-bundle or mid-OUT: everything returns to reset values immediately and the partial bundle is lost.

Optional Feature:
- Macro: HV_TIEBREAK_EN.
- Defined:
  - Tie bits take the corresponding bit of a 32-bit Galois LFSR (taps 32,22,2,1).
  - The LFSR advances once per completed bundle, on the OUT handshake.
  - Reset value is LFSR_SEED; clear does not reset it.
- Undefined:
  - Tie bits resolve to 0.
  - No LFSR logic is synthesized.

Test Plan:
- Single beat in_d=32'hF0F0_F0F0 with in_last -> one cycle later out_v=1, out_d=32'hF0F0_F0F0, out_n=1; in_r=0 until handshake.
- Three beats 32'hFFFF_0000, 32'hFF00_FF00, 32'hF0F0_F0F0 (last), out_r=1 -> out_d=32'hFFF0_F000, out_n=3, then IDLE.
- Two beats 32'hFFFF_FFFF, 32'h0000_0000 (all ties), macro off -> out_d=0; macro on -> out_d=LFSR_SEED, and the next all-tie bundle returns the advanced LFSR value.
- 200 beats of 32'hFFFF_FFFF then last, CNT_W=8 -> counters saturate at +127, out_d=32'hFFFF_FFFF, out_n=200; 300 beats -> out_n=255.
- clear asserted during ACC after 5 beats, then one beat 32'h0000_00FF with last -> out_d=32'h0000_00FF, out_n=1. clear with out_v=1 and out_r=1 -> no handshake, out_v=0.
- rst pulsed low mid-ACC and asynchronously (between clk edges) -> outputs reach reset values before the next edge; the following single-beat bundle equals its input.
